// File: rtl/satatrn_txsched_if.sv
// satatrn_txsched_if: data-path bundle between the command engine, the write
// scheduler and the transport TX arbiter data port.
//
// Signal names are given from the scheduler's point of view:
//   i_dma_activate  RX path -> scheduler, one-cycle DMA Activate FIS pulse
//   o_txgate        scheduler -> arbiter, permits a DATA FIS to open
//   i_valid/o_ready/i_data          upstream stream (command engine side)
//   o_valid/i_ready/o_data/o_last   downstream stream (arbiter side)
//
// master: the surrounding environment; slave: the scheduler.
interface satatrn_txsched_if;
    logic        i_dma_activate;
    logic        o_txgate;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_data;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_data;
    logic        o_last;

    modport master (
        output i_dma_activate, i_valid, i_data, i_ready,
        input  o_txgate, o_ready, o_valid, o_data, o_last
    );

    modport slave (
        input  i_dma_activate, i_valid, i_data, i_ready,
        output o_txgate, o_ready, o_valid, o_data, o_last
    );
endinterface

// File: rtl/satatrn_txsched.sv
// satatrn_txsched: transport-layer write-data scheduler.
//
// Paces a write command into DATA FIS payloads of at most 2^LGMAXFIS dwords.
// Each payload is released only after a DMA Activate FIS; the wait for it is
// bounded by 2^LGTIMEOUT clocks.
//
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_start, i_len   begin a transfer of i_len dwords (sampled in IDLE)
//   i_abort          cancel the transfer, highest priority
//   o_busy           state is not IDLE
//   o_done, o_err    one-cycle completion / DMA Activate timeout pulses
//   bus              data path and TX gate (see satatrn_txsched_if)
module satatrn_txsched #(
    parameter int unsigned LGLEN     = 23,
    parameter int unsigned LGMAXFIS  = 11,
    parameter int unsigned LGTIMEOUT = 20
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [LGLEN-1:0] i_len,
    input  logic             i_abort,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    satatrn_txsched_if.slave bus
);

    localparam int unsigned          CW        = LGMAXFIS + 1;
    localparam logic [LGLEN-1:0]     MAX_FIS   = LGLEN'(1) << LGMAXFIS;
    localparam logic [CW-1:0]        CHUNK_ONE = CW'(1);
    localparam logic [LGLEN-1:0]     REM_ONE   = LGLEN'(1);
    localparam logic [LGTIMEOUT-1:0] TMO_MAX   = '1;

    typedef enum logic [1:0] {
        StIdle,
        StWaitAct,
        StSend,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic [LGLEN-1:0]     remaining_q, remaining_d;
    logic [CW-1:0]        chunk_q, chunk_d;
    logic [LGTIMEOUT-1:0] tmo_q, tmo_d;
    logic                 last_q;

    logic done, err, txgate, valid, ready;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        chunk_d     = chunk_q;
        tmo_d       = tmo_q;
        done        = 1'b0;
        err         = 1'b0;
        txgate      = 1'b0;
        valid       = 1'b0;
        ready       = 1'b0;

        case (state_q)
            StIdle: begin
                if (i_start) begin
                    if (i_len != '0) begin
                        remaining_d = i_len;
                        tmo_d       = '0;
                        state_d     = StWaitAct;
                    end else begin
                        state_d = StDone;
                    end
                end
            end

            StWaitAct: begin
                tmo_d = tmo_q + LGTIMEOUT'(1);
                // Activate wins over a simultaneous terminal count.
                if (bus.i_dma_activate) begin
                    chunk_d = (remaining_q > MAX_FIS) ? CW'(MAX_FIS) : CW'(remaining_q);
                    state_d = StSend;
                end else if (tmo_q == TMO_MAX) begin
                    err     = 1'b1;
                    state_d = StIdle;
                end
            end

            StSend: begin
                txgate = 1'b1;
                valid  = bus.i_valid;
                ready  = bus.i_ready;
                if (bus.i_valid && bus.i_ready) begin
                    chunk_d     = chunk_q - CHUNK_ONE;
                    remaining_d = remaining_q - REM_ONE;
                    if (chunk_q == CHUNK_ONE) begin
                        if (remaining_q == REM_ONE) begin
                            state_d = StDone;
                        end else begin
                            tmo_d   = '0;
                            state_d = StWaitAct;
                        end
                    end
                end
            end

            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end

            default: state_d = StIdle;
        endcase

        // Abort overrides everything: no beat, no pulse, counters untouched.
        if (i_abort) begin
            state_d     = StIdle;
            remaining_d = remaining_q;
            chunk_d     = chunk_q;
            done        = 1'b0;
            err         = 1'b0;
            valid       = 1'b0;
            ready       = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            chunk_q     <= '0;
            tmo_q       <= '0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            chunk_q     <= chunk_d;
            tmo_q       <= tmo_d;
            // Registered look-ahead of chunk==1 so o_last carries no compare path.
            last_q      <= (state_d == StSend) && (chunk_d == CHUNK_ONE);
        end
    end

    assign o_busy       = (state_q != StIdle);
    assign o_done       = done;
    assign o_err        = err;
    assign bus.o_txgate = txgate;
    assign bus.o_valid  = valid;
    assign bus.o_ready  = ready;
    assign bus.o_data   = bus.i_data;
    assign bus.o_last   = last_q;

endmodule

// File: tb/tb_satatrn_txsched.sv
module tb_satatrn_txsched;

    localparam int unsigned LGLEN     = 8;
    localparam int unsigned LGMAXFIS  = 2;
    localparam int unsigned LGTIMEOUT = 4;
    localparam int          MAXFIS_DW = 4;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    typedef struct {
        int         len;
        logic [3:0] rmask;
        int         exp_acts;
        int         exp_beats;
        int         exp_done;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LGLEN-1:0] len;
    logic             abort;
    logic             busy;
    logic             done;
    logic             err;

    satatrn_txsched_if bus ();

    satatrn_txsched #(
        .LGLEN     (LGLEN),
        .LGMAXFIS  (LGMAXFIS),
        .LGTIMEOUT (LGTIMEOUT)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_start (start),
        .i_len   (len),
        .i_abort (abort),
        .o_busy  (busy),
        .o_done  (done),
        .o_err   (err),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          beat_cnt = 0;
    int          done_cnt = 0;
    int          err_cnt  = 0;
    logic        gate_seen = 1'b0;
    logic [31:0] data_base = 32'h0;
    exp_t        sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Downstream monitor: every beat pops the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (bus.o_valid && bus.i_ready) begin
            beat_cnt++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL beat_unexpected: got beat %0d data 0x%0h, expected no beat",
                         beat_cnt, bus.o_data);
            end else begin
                e = sb.pop_front();
                check("beat_data", bus.o_data, e.data);
                check("beat_last", 32'(bus.o_last), 32'(e.last));
            end
        end
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (bus.o_txgate) gate_seen = 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
        bus.i_data = data_base + beat_cnt;
    endtask

    task automatic clear(input logic [31:0] base);
        beat_cnt  = 0;
        done_cnt  = 0;
        err_cnt   = 0;
        gate_seen = 1'b0;
        data_base = base;
        sb.delete();
    endtask

    // Expect n beats of a total-dword command, FIS boundaries every MAXFIS_DW.
    task automatic push_exp(input int n, input int total);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.data = data_base + i;
            e.last = (((i + 1) % MAXFIS_DW) == 0) || ((i + 1) == total);
            sb.push_back(e);
        end
    endtask

    task automatic idle_inputs();
        start              = 1'b0;
        abort              = 1'b0;
        bus.i_dma_activate = 1'b0;
        bus.i_valid        = 1'b0;
        bus.i_ready        = 1'b0;
    endtask

    // Full transfer with the bench acting as device: activate 2 cycles into each wait.
    task automatic run_xfer(input int l, input logic [3:0] rmask, output int acts);
        int cyc;
        int wait_cnt;
        cyc      = 0;
        wait_cnt = 0;
        acts     = 0;
        clear(32'hC000_0000 + (l << 8));
        push_exp(l, l);
        step();
        start = 1'b1;
        len   = LGLEN'(l);
        step();
        start = 1'b0;
        while (done_cnt == 0 && err_cnt == 0 && cyc < 300) begin
            bus.i_dma_activate = 1'b0;
            bus.i_valid        = 1'b1;
            bus.i_ready        = rmask[cyc % 4];
            if (busy && !bus.o_txgate && !done) begin
                wait_cnt++;
                if (wait_cnt == 2) begin
                    bus.i_dma_activate = 1'b1;
                    acts++;
                    wait_cnt = 0;
                end
            end
            step();
            cyc++;
        end
        if (cyc >= 300) begin
            n_checks++;
            n_fail++;
            $display("FAIL xfer_timeout: got no o_done within 300 cycles, expected completion");
        end
        idle_inputs();
        step();
        step();
    endtask

    vec_t vecs[7];

    initial begin
        int acts;
        int err_at;
        logic busy_after;

        vecs[0] = '{len: 3,  rmask: 4'b1111, exp_acts: 1, exp_beats: 3,  exp_done: 1};
        vecs[1] = '{len: 10, rmask: 4'b1111, exp_acts: 3, exp_beats: 10, exp_done: 1};
        vecs[2] = '{len: 4,  rmask: 4'b0101, exp_acts: 1, exp_beats: 4,  exp_done: 1};
        vecs[3] = '{len: 4,  rmask: 4'b1111, exp_acts: 1, exp_beats: 4,  exp_done: 1};
        vecs[4] = '{len: 5,  rmask: 4'b0011, exp_acts: 2, exp_beats: 5,  exp_done: 1};
        vecs[5] = '{len: 8,  rmask: 4'b1111, exp_acts: 2, exp_beats: 8,  exp_done: 1};
        vecs[6] = '{len: 1,  rmask: 4'b1101, exp_acts: 1, exp_beats: 1,  exp_done: 1};

        idle_inputs();
        len         = '0;
        bus.i_data  = 32'h0;
        rst         = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        // Reset state, upstream offering data while idle.
        bus.i_valid = 1'b1;
        bus.i_ready = 1'b1;
        bus.i_data  = 32'h1234_5678;
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_txgate", 32'(bus.o_txgate), 0);
        check("rst_valid", 32'(bus.o_valid), 0);
        check("rst_ready", 32'(bus.o_ready), 0);
        check("rst_last", 32'(bus.o_last), 0);
        check("idle_data_pass", bus.o_data, 32'h1234_5678);
        idle_inputs();

        // Single FIS with exact timing; an activate during SEND must be ignored.
        clear(32'hA0);
        push_exp(3, 3);
        step();
        start = 1'b1;
        len   = 8'd3;
        @(negedge clk);
        check("single_busy_start_cycle", 32'(busy), 0);
        step();
        start = 1'b0;
        @(negedge clk);
        check("single_busy_wait", 32'(busy), 1);
        check("single_gate_wait", 32'(bus.o_txgate), 0);
        step();
        bus.i_dma_activate = 1'b1;
        @(negedge clk);
        check("single_gate_act_cycle", 32'(bus.o_txgate), 0);
        step();
        bus.i_dma_activate = 1'b0;
        bus.i_valid        = 1'b1;
        bus.i_ready        = 1'b1;
        @(negedge clk);
        check("single_gate_send", 32'(bus.o_txgate), 1);
        check("single_valid_send", 32'(bus.o_valid), 1);
        check("single_ready_send", 32'(bus.o_ready), 1);
        step();
        bus.i_dma_activate = 1'b1;
        step();
        bus.i_dma_activate = 1'b0;
        step();
        @(negedge clk);
        check("single_done_pulse", 32'(done), 1);
        check("single_gate_after", 32'(bus.o_txgate), 0);
        check("single_valid_after", 32'(bus.o_valid), 0);
        check("single_busy_in_done", 32'(busy), 1);
        step();
        @(negedge clk);
        check("single_busy_end", 32'(busy), 0);
        check("single_done_once", 32'(done), 0);
        idle_inputs();
        step();
        check("single_beats", beat_cnt, 3);
        check("single_done_cnt", done_cnt, 1);
        check("single_sb_empty", sb.size(), 0);

        // Table-driven transfers.
        foreach (vecs[i]) begin
            run_xfer(vecs[i].len, vecs[i].rmask, acts);
            check($sformatf("vec%0d_acts", i), acts, vecs[i].exp_acts);
            check($sformatf("vec%0d_beats", i), beat_cnt, vecs[i].exp_beats);
            check($sformatf("vec%0d_done", i), done_cnt, vecs[i].exp_done);
            check($sformatf("vec%0d_err", i), err_cnt, 0);
            check($sformatf("vec%0d_sb_empty", i), sb.size(), 0);
        end

        // Timeout on the first wait.
        clear(32'hE0);
        step();
        start = 1'b1;
        len   = 8'd5;
        step();
        start      = 1'b0;
        err_at     = 0;
        busy_after = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (err) err_at = k;
            if (err_at != 0 && k == err_at + 1) busy_after = busy;
            step();
        end
        check("tmo1_err_cycle", err_at, 16);
        check("tmo1_busy_after", 32'(busy_after), 0);
        check("tmo1_err_cnt", err_cnt, 1);
        check("tmo1_done_cnt", done_cnt, 0);

        // Timeout on the second wait, after one full FIS.
        clear(32'hF0);
        push_exp(4, 6);
        step();
        start = 1'b1;
        len   = 8'd6;
        step();
        start              = 1'b0;
        bus.i_dma_activate = 1'b1;
        step();
        bus.i_dma_activate = 1'b0;
        bus.i_valid        = 1'b1;
        bus.i_ready        = 1'b1;
        repeat (4) step();
        err_at     = 0;
        busy_after = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (err) err_at = k;
            if (err_at != 0 && k == err_at + 1) busy_after = busy;
            step();
        end
        idle_inputs();
        check("tmo2_err_cycle", err_at, 16);
        check("tmo2_busy_after", 32'(busy_after), 0);
        check("tmo2_err_cnt", err_cnt, 1);
        check("tmo2_beats", beat_cnt, 4);
        check("tmo2_done_cnt", done_cnt, 0);
        check("tmo2_sb_empty", sb.size(), 0);

        // Abort mid-SEND, then a normal transfer.
        clear(32'hB0);
        push_exp(2, 8);
        step();
        start = 1'b1;
        len   = 8'd8;
        step();
        start              = 1'b0;
        bus.i_dma_activate = 1'b1;
        step();
        bus.i_dma_activate = 1'b0;
        bus.i_valid        = 1'b1;
        bus.i_ready        = 1'b1;
        step();
        step();
        abort = 1'b1;
        @(negedge clk);
        check("abort_valid", 32'(bus.o_valid), 0);
        check("abort_ready", 32'(bus.o_ready), 0);
        check("abort_done", 32'(done), 0);
        step();
        abort       = 1'b0;
        bus.i_valid = 1'b0;
        @(negedge clk);
        check("abort_busy_next", 32'(busy), 0);
        check("abort_gate_next", 32'(bus.o_txgate), 0);
        step();
        check("abort_beats", beat_cnt, 2);
        check("abort_done_cnt", done_cnt, 0);
        check("abort_err_cnt", err_cnt, 0);
        check("abort_sb_empty", sb.size(), 0);
        idle_inputs();
        run_xfer(3, 4'b1111, acts);
        check("post_abort_done", done_cnt, 1);
        check("post_abort_beats", beat_cnt, 3);

        // Zero-length command.
        clear(32'h0);
        step();
        start = 1'b1;
        len   = 8'd0;
        step();
        start       = 1'b0;
        bus.i_valid = 1'b1;
        bus.i_ready = 1'b1;
        @(negedge clk);
        check("len0_done", 32'(done), 1);
        check("len0_gate", 32'(bus.o_txgate), 0);
        step();
        @(negedge clk);
        check("len0_busy_end", 32'(busy), 0);
        check("len0_done_once", 32'(done), 0);
        idle_inputs();
        step();
        check("len0_gate_never", 32'(gate_seen), 0);
        check("len0_beats", beat_cnt, 0);

        // Reset while in SEND.
        clear(32'hD0);
        push_exp(2, 8);
        step();
        start = 1'b1;
        len   = 8'd8;
        step();
        start              = 1'b0;
        bus.i_dma_activate = 1'b1;
        step();
        bus.i_dma_activate = 1'b0;
        bus.i_valid        = 1'b1;
        bus.i_ready        = 1'b1;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rsend_busy", 32'(busy), 0);
        check("rsend_done", 32'(done), 0);
        check("rsend_err", 32'(err), 0);
        check("rsend_gate", 32'(bus.o_txgate), 0);
        check("rsend_valid", 32'(bus.o_valid), 0);
        check("rsend_ready", 32'(bus.o_ready), 0);
        check("rsend_last", 32'(bus.o_last), 0);
        idle_inputs();
        step();
        check("rsend_beats", beat_cnt, 2);
        check("rsend_sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running at 500000, expected $finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/satatrn_txsched.md
# satatrn_txsched

Transport-layer write-data scheduler for the SATA host. It sits between the command engine's outbound data stream and the transport TX arbiter's data port, and paces a write command into DATA FIS payloads. Each payload is released only after the device grants it with a DMA Activate FIS. No payload exceeds 2^LGMAXFIS dwords. It drives the TX gate, marks the last dword of each FIS, and reports completion, timeout or abort.

## Interface

Parameters:
- LGLEN, 23: width of the transfer length in dwords. Maximum transfer is 2^LGLEN−1 dwords.
- LGMAXFIS, 11: log2 of the maximum DATA FIS payload in dwords. Default 2048 dwords = 8 KiB.
- LGTIMEOUT, 20: log2 of the DMA Activate wait timeout in clocks.

Ports:
- i_clk  in  1  sole clock
- i_reset  in  1  synchronous, active-high reset
- i_start  in  1  begin transfer; sampled only in IDLE
- i_len  in  LGLEN  transfer length in dwords; sampled with i_start
- i_abort  in  1  cancel the transfer (link error or R_ERR)
- o_busy  out  1  state ≠ IDLE
- o_done  out  1  one-cycle pulse: all dwords sent
- o_err  out  1  one-cycle pulse: DMA Activate timeout
- i_dma_activate  in  1  one-cycle pulse from the RX path: DMA Activate FIS received
- o_txgate  out  1  permits the TX arbiter to open a DATA FIS
- i_valid  in  1  upstream data valid
- o_ready  out  1  upstream data ready
- i_data  in  32  upstream dword
- o_valid  out  1  downstream data valid, toward the arbiter data port
- i_ready  in  1  downstream ready
- o_data  out  32  downstream dword
- o_last  out  1  last dword of the current FIS

## Operation

- State machine: IDLE, WAIT_ACT, SEND, DONE.
- Registers:
  - remaining: LGLEN bits, dwords still to send in the command.
  - chunk: LGMAXFIS+1 bits, dwords left in the current FIS.
  - tmo: LGTIMEOUT bits.
- IDLE:
  - i_start && i_len≠0: load remaining=i_len, clear tmo, go to WAIT_ACT.
  - i_start && i_len==0: go to DONE.
  - Otherwise stay in IDLE.
- WAIT_ACT:
  - tmo increments every cycle.
  - i_dma_activate: load chunk = min(remaining, 2^LGMAXFIS), go to SEND.
  - tmo == 2^LGTIMEOUT−1 with no i_dma_activate: pulse o_err, go to IDLE.
  - If i_dma_activate and the terminal count occur in the same cycle, activate wins.
- SEND:
  - o_txgate=1.
  - Data passes through combinationally: o_valid = i_valid; o_ready = i_ready; o_data = i_data; o_last = (chunk==1).
  - On each beat (o_valid && i_ready), chunk and remaining both decrement.
  - On a beat with chunk==1:
    - If remaining==1, go to DONE.
    - Otherwise clear tmo and go to WAIT_ACT.
  - i_dma_activate during SEND is ignored.
- DONE: o_done=1 for exactly one cycle, then IDLE.
- Outside SEND, o_valid=0, o_ready=0 and o_txgate=0. o_data equals i_data at all times.
- i_abort has priority over every transition in every state:
  - Next state is IDLE.
  - No o_done and no o_err.
  - In the abort cycle, o_valid and o_ready are forced to 0, so no beat is transferred.
- i_start outside IDLE is ignored.
- Reset values: state IDLE; o_busy, o_done, o_err, o_txgate, o_valid, o_ready and o_last all 0; remaining, chunk and tmo all 0.

## Timing

- i_start in IDLE at cycle N: o_busy=1 at N+1 (WAIT_ACT).
- i_dma_activate at cycle M in WAIT_ACT: o_txgate=1 and data may flow from M+1.
- Final beat of a FIS at cycle K:
  - o_txgate=0 from K+1.
  - If it was the command's final beat, o_done pulses at K+1 and o_busy=0 at K+2.
- Timeout: o_err asserts 2^LGTIMEOUT cycles after entering WAIT_ACT when no activate arrives. o_busy=0 on the following cycle.
- Throughput in SEND: one dword per clock while i_valid && i_ready.
- o_valid, o_ready and o_data carry zero registered latency through SEND.
- o_last is a registered compare of chunk.

## Test plan

All scenarios use LGMAXFIS=2 and LGTIMEOUT=4.

- Single FIS: start with i_len=3; activate; stream 3 dwords 0xA0..0xA2 with i_ready=1 → exactly 3 beats; o_last on 0xA2 only; o_done pulses 1 cycle after the 0xA2 beat.
- Split FIS: i_len=10; activate three times → FIS sizes 4, 4, 2; o_last on beats 4, 8 and 10; o_txgate=0 between the activates; one o_done.
- Backpressure: i_len=4; toggle i_ready 1,0,1,0 and hold i_valid=1 → data order preserved; chunk and remaining decrement only on handshake cycles; 4 beats total.
- Timeout: i_len=5 with no activate → o_err pulses 16 cycles after entering WAIT_ACT; o_busy=0 the next cycle; no o_done. Repeat after the first FIS of i_len=6 → o_err after the second wait.
- Abort mid-SEND: i_len=8; activate; 2 beats; assert i_abort with i_valid=i_ready=1 → that cycle has o_valid=0; state IDLE next cycle; no o_done or o_err; a new i_start is then accepted normally.
- Edge cases:
  - i_len=0 → o_done on the cycle after start, o_txgate never asserted.
  - i_reset asserted in SEND → all outputs 0 on the next cycle.
